// File: rtl/clockworks_pkg.sv
// Shared constants and helpers for the clockworks clock/reset block.
package clockworks_pkg;

    localparam int HOLD_W   = 8;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = (1 << HOLD_W) - 1;

    function automatic logic [HOLD_W-1:0] to_hold(input int n);
        return n[HOLD_W-1:0];
    endfunction

endpackage

// File: rtl/clockworks_reset_stretcher.sv
// Holds reset_n low for a fixed number of wrap strobes after RESET releases.
module clockworks_reset_stretcher
    import clockworks_pkg::*;
#(
    parameter logic [HOLD_W-1:0] HOLD = 8'd4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_wrap,
    output logic o_reset_n
);

    // Initial values give the FPGA power-up state: as if RESET just released.
    logic [HOLD_W-1:0] r_hold  = '0;
    logic              r_rst_n = 1'b0;
    logic [HOLD_W-1:0] w_hold_next;

    assign w_hold_next = r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold  <= '0;
            r_rst_n <= 1'b0;
        end else if (!r_rst_n && i_wrap) begin
            r_hold <= w_hold_next;
            if (w_hold_next == HOLD) begin
                r_rst_n <= 1'b1;
            end
        end
    end

    assign o_reset_n = r_rst_n;

endmodule

// File: rtl/clockworks.sv
// Power-of-two clock divider plus a reset stretched over whole slow-clock periods.
module clockworks
    import clockworks_pkg::*;
#(
    parameter int SLOW       = 21,
    parameter int RESET_HOLD = 4
) (
    input  logic clock_in,
    input  logic RESET,
    output logic clock_out,
    output logic reset_n_out
);

    logic w_wrap;

    generate
        if (SLOW == 0) begin : g_bypass
            // Hold logic then counts raw clock_in cycles.
            assign clock_out = clock_in;
            assign w_wrap    = 1'b1;
        end else begin : g_div
            logic [SLOW:0] r_div_cnt = '0;

            always_ff @(posedge clock_in) begin
                if (RESET) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + {{SLOW{1'b0}}, 1'b1};
                end
            end

            assign clock_out = r_div_cnt[SLOW];
            assign w_wrap    = &r_div_cnt;
        end
    endgenerate

    clockworks_reset_stretcher #(
        .HOLD(to_hold(RESET_HOLD))
    ) u_stretcher (
        .i_clk     (clock_in),
        .i_reset   (RESET),
        .i_wrap    (w_wrap),
        .o_reset_n (reset_n_out)
    );

endmodule

// File: tb/tb_clockworks.sv
// Self-checking bench: three clockworks configurations against an edge-count model.
module tb_clockworks;

    logic clk = 1'b0;
    logic rst0 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
    logic s0_clk, s0_rstn, s2_clk, s2_rstn, s3_clk, s3_rstn;

    int checks = 0;
    int errors = 0;
    int k0 = 0, k2 = 0, k3 = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    clockworks #(.SLOW(0), .RESET_HOLD(3)) u_s0 (
        .clock_in(clk), .RESET(rst0), .clock_out(s0_clk), .reset_n_out(s0_rstn));
    clockworks #(.SLOW(2), .RESET_HOLD(2)) u_s2 (
        .clock_in(clk), .RESET(rst2), .clock_out(s2_clk), .reset_n_out(s2_rstn));
    clockworks #(.SLOW(3), .RESET_HOLD(1)) u_s3 (
        .clock_in(clk), .RESET(rst3), .clock_out(s3_clk), .reset_n_out(s3_rstn));

    // k = clock_in edges since the last edge with RESET=1 (or since power-up).
    function automatic int period_of(input int slow);
        return (slow == 0) ? 1 : (1 << (slow + 1));
    endfunction

    function automatic logic exp_clk(input int k, input int slow);
        int p;
        p = 1 << (slow + 1);
        return ((k % p) >= (p / 2)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_rstn(input int k, input int slow, input int hold);
        return (k >= hold * period_of(slow)) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model update and per-cycle comparison.
    initial begin
        while (!done) begin
            @(posedge clk);
            k0 = rst0 ? 0 : k0 + 1;
            k2 = rst2 ? 0 : k2 + 1;
            k3 = rst3 ? 0 : k3 + 1;
            #1;
            chk("s0_clk_high", s0_clk, 1'b1);
            @(negedge clk);
            chk("s0_clk_low", s0_clk, 1'b0);
            chk("s0_rstn", s0_rstn, exp_rstn(k0, 0, 3));
            chk("s2_clk", s2_clk, exp_clk(k2, 2));
            chk("s2_rstn", s2_rstn, exp_rstn(k2, 2, 2));
            chk("s3_clk", s3_clk, exp_clk(k3, 3));
            chk("s3_rstn", s3_rstn, exp_rstn(k3, 3, 1));
        end
    end

    initial begin
        int w;

        // Power-up with RESET low, literal pins.
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk);
            #1;
            if (c == 3)  chk("pin_pu_s2_clk3", s2_clk, 1'b0);
            if (c == 4)  chk("pin_pu_s2_clk4", s2_clk, 1'b1);
            if (c == 8)  chk("pin_pu_s2_clk8", s2_clk, 1'b0);
            if (c == 12) chk("pin_pu_s2_clk12", s2_clk, 1'b1);
            if (c == 15) chk("pin_pu_s2_rstn15", s2_rstn, 1'b0);
            if (c == 16) chk("pin_pu_s2_rstn16", s2_rstn, 1'b1);
            if (c == 116) chk("pin_pu_s2_rstn116", s2_rstn, 1'b1);
            if (c == 2)  chk("pin_pu_s0_rstn2", s0_rstn, 1'b0);
            if (c == 3)  chk("pin_pu_s0_rstn3", s0_rstn, 1'b1);
            if (c == 15) chk("pin_pu_s3_rstn15", s3_rstn, 1'b0);
            if (c == 16) chk("pin_pu_s3_rstn16", s3_rstn, 1'b1);
        end

        // s2: 3-cycle RESET during the clock_out high phase.
        w = 0;
        @(negedge clk);
        while ((k2 % 8) != 5 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("wait_s2_high_phase", ((k2 % 8) == 5) ? 1'b1 : 1'b0, 1'b1);
        chk("pin_mid_s2_clk_before", s2_clk, 1'b1);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("pin_mid_s2_clk_rst", s2_clk, 1'b0);
        chk("pin_mid_s2_rstn_rst", s2_rstn, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            if (c == 3)  chk("pin_mid_s2_clk3", s2_clk, 1'b0);
            if (c == 4)  chk("pin_mid_s2_clk4", s2_clk, 1'b1);
            if (c == 15) chk("pin_mid_s2_rstn15", s2_rstn, 1'b0);
            if (c == 16) chk("pin_mid_s2_rstn16", s2_rstn, 1'b1);
        end

        // s2: RESET exactly on the wrap edge while still in hold.
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        w = 0;
        while (k2 != 7 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("wait_s2_wrap", (k2 == 7) ? 1'b1 : 1'b0, 1'b1);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            if (c == 8)  chk("pin_wrap_s2_rstn8", s2_rstn, 1'b0);
            if (c == 15) chk("pin_wrap_s2_rstn15", s2_rstn, 1'b0);
            if (c == 16) chk("pin_wrap_s2_rstn16", s2_rstn, 1'b1);
        end

        // s3 and s0: pulse RESET while already released.
        @(negedge clk);
        chk("pin_s3_rstn_before", s3_rstn, 1'b1);
        rst3 = 1'b1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("pin_s3_rstn_pulse", s3_rstn, 1'b0);
        chk("pin_s0_rstn_pulse", s0_rstn, 1'b0);
        @(negedge clk);
        rst3 = 1'b0;
        rst0 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            if (c == 2)  chk("pin_s0_rstn2", s0_rstn, 1'b0);
            if (c == 3)  chk("pin_s0_rstn3", s0_rstn, 1'b1);
            if (c == 15) chk("pin_s3_rstn15", s3_rstn, 1'b0);
            if (c == 16) chk("pin_s3_rstn16", s3_rstn, 1'b1);
        end

        // Random RESET activity on all three instances.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst0 = ($urandom_range(0, 29) == 0);
            rst2 = ($urandom_range(0, 49) == 0);
            rst3 = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst2 = 1'b0;
        rst3 = 1'b0;
        repeat (40) @(negedge clk);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
